mc_cpu_core: RTL and testbench

Parametrised multi-cycle successor to the 16-bit pipelined CPU top level.
- Single FSM sequences fetch/decode/execute/memory/writeback.
- Configurable data width, register count and PC width.
- External instruction and data memories reached over req/ack handshakes; wait-state tolerant.
- Sits at the top of the core; DataOut exposes each writeback result, as the existing top level does.

---
 rtl/mc_cpu_core_if.sv | 31 +++
 rtl/mc_cpu_core.sv | 244 ++++++++++++++++++++++++
 tb/tb_mc_cpu_core.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_cpu_core_if.sv
// Bus interface for mc_cpu_core: instruction fetch and data memory req/ack channels.
// The core drives the master side; the memory system drives the slave side.
interface mc_cpu_core_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 12
);
  logic [PC_W-1:0]   imem_addr;
  logic              imem_req;
  logic [15:0]       imem_rdata;
  logic              imem_ack;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_we;
  logic              dmem_req;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output imem_addr, imem_req,
    input  imem_rdata, imem_ack,
    output dmem_addr, dmem_wdata, dmem_we, dmem_req,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  imem_addr, imem_req,
    output imem_rdata, imem_ack,
    input  dmem_addr, dmem_wdata, dmem_we, dmem_req,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mc_cpu_core.sv
// Multi-cycle CPU core: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer with req/ack memory buses.
// Optional macro MC_CPU_MUL_EN enables the MUL opcode (10); otherwise it executes as NOP.
module mc_cpu_core #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 16,
  parameter int PC_W    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  mc_cpu_core_if.master     bus,
  output logic [DATA_W-1:0] DataOut,
  output logic              retire,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_LD   = 4'd6;
  localparam logic [3:0] OP_ST   = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_JMP  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_HALT = 4'd15;

  state_t            r_state;
  state_t            w_state_next;
  logic [PC_W-1:0]   r_pc;
  logic [15:0]       r_instr;
  logic [DATA_W-1:0] r_a;       // rs value
  logic [DATA_W-1:0] r_b;       // rt value
  logic [DATA_W-1:0] r_d;       // rd value (store data / BEQ operand)
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_dataout;
  logic              r_imem_req;
  logic              r_dmem_req;
  logic              r_dmem_we;
  logic              r_retire;
  logic              r_halted;

  logic [3:0]        w_op;
  logic [3:0]        w_rd;
  logic [3:0]        w_rs;
  logic [3:0]        w_rt;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_ea;
  logic              w_is_alu;
  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_pc_br;
  logic [PC_W-1:0]   w_pc_jmp;
  logic [PC_W-1:0]   w_pc_next;
  logic              w_retire_next;
  logic              w_imem_acc;
  logic              w_dmem_acc;
  logic [DATA_W-1:0] w_rf [16];

  assign w_op  = r_instr[15:12];
  assign w_rd  = r_instr[11:8];
  assign w_rs  = r_instr[7:4];
  assign w_rt  = r_instr[3:0];
  assign w_imm = DATA_W'($signed(w_rt));
  assign w_ea  = r_a + w_imm;

  // A request only counts as accepted when it is actually outstanding.
  assign w_imem_acc = r_imem_req && bus.imem_ack;
  assign w_dmem_acc = r_dmem_req && bus.dmem_ack;

  // Register file: slots outside REG_CNT and r0 are hard-wired to zero.
  for (genvar gi = 0; gi < 16; gi++) begin : g_rf
    if (gi > 0 && gi < REG_CNT) begin : g_reg
      logic [DATA_W-1:0] r_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_q <= '0;
        end else if (enable && r_state == S_WB && w_rd == 4'(gi)) begin
          r_q <= r_result;
        end
      end
      assign w_rf[gi] = r_q;
    end else begin : g_zero
      assign w_rf[gi] = '0;
    end
  end

`ifdef MC_CPU_MUL_EN
  logic [DATA_W-1:0] w_mul;
  assign w_mul    = r_a * r_b;
  assign w_is_alu = (w_op >= OP_ADD && w_op <= OP_ADDI) || (w_op == OP_MUL);
`else
  assign w_is_alu = (w_op >= OP_ADD && w_op <= OP_ADDI);
`endif

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = r_a + r_b;
      OP_SUB:  w_alu = r_a - r_b;
      OP_AND:  w_alu = r_a & r_b;
      OP_OR:   w_alu = r_a | r_b;
      OP_ADDI: w_alu = r_a + w_imm;
`ifdef MC_CPU_MUL_EN
      OP_MUL:  w_alu = w_mul;
`endif
      default: w_alu = '0;
    endcase
  end

  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_pc_br  = w_pc_inc + PC_W'($signed(w_rt));
  assign w_pc_jmp = PC_W'(r_instr[11:0]);

  always_comb begin
    w_pc_next = w_pc_inc;
    case (w_op)
      OP_BEQ:  w_pc_next = (r_d == r_a) ? w_pc_br : w_pc_inc;
      OP_JMP:  w_pc_next = w_pc_jmp;
      OP_HALT: w_pc_next = r_pc;
      default: w_pc_next = w_pc_inc;
    endcase
  end

  always_comb begin
    w_state_next  = r_state;
    w_retire_next = 1'b0;
    case (r_state)
      S_FETCH:  if (w_imem_acc) w_state_next = S_DECODE;
      S_DECODE: w_state_next = S_EXEC;
      S_EXEC: begin
        if (w_op == OP_HALT) begin
          w_state_next  = S_HALT;
          w_retire_next = 1'b1;
        end else if (w_is_alu) begin
          w_state_next = S_WB;
        end else if (w_op == OP_LD || w_op == OP_ST) begin
          w_state_next = S_MEM;
        end else begin
          w_state_next  = S_FETCH;
          w_retire_next = 1'b1;
        end
      end
      S_MEM: begin
        if (w_dmem_acc) begin
          if (w_op == OP_ST) begin
            w_state_next  = S_FETCH;
            w_retire_next = 1'b1;
          end else begin
            w_state_next = S_WB;
          end
        end
      end
      S_WB: begin
        w_state_next  = S_FETCH;
        w_retire_next = 1'b1;
      end
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_FETCH;
    endcase
  end

  // Bus and status outputs are registered from the next state, so they are
  // all low during reset and drop the cycle after a handshake completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_FETCH;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_retire   <= 1'b0;
      r_halted   <= 1'b0;
    end else if (enable) begin
      r_state    <= w_state_next;
      r_imem_req <= (w_state_next == S_FETCH);
      r_dmem_req <= (w_state_next == S_MEM);
      r_dmem_we  <= (w_state_next == S_MEM) && (w_op == OP_ST);
      r_retire   <= w_retire_next;
      r_halted   <= (w_state_next == S_HALT);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc      <= '0;
      r_instr   <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_d       <= '0;
      r_result  <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_dataout <= '0;
    end else if (enable) begin
      case (r_state)
        S_FETCH: begin
          if (w_imem_acc) r_instr <= bus.imem_rdata;
        end
        S_DECODE: begin
          r_a <= w_rf[w_rs];
          r_b <= w_rf[w_rt];
          r_d <= w_rf[w_rd];
        end
        S_EXEC: begin
          r_result <= w_alu;
          r_addr   <= w_ea;
          r_wdata  <= r_d;
          r_pc     <= w_pc_next;
        end
        S_MEM: begin
          if (w_dmem_acc && w_op == OP_LD) r_result <= bus.dmem_rdata;
        end
        S_WB: begin
          r_dataout <= r_result;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.imem_addr  = r_pc;
  assign bus.imem_req   = r_imem_req;
  assign bus.dmem_addr  = r_addr;
  assign bus.dmem_wdata = r_wdata;
  assign bus.dmem_we    = r_dmem_we;
  assign bus.dmem_req   = r_dmem_req;
  assign DataOut        = r_dataout;
  assign retire         = r_retire;
  assign halted         = r_halted;

endmodule

// File: tb/tb_mc_cpu_core.sv
// Scoreboard bench for mc_cpu_core: an instruction-level ISA model predicts fetches,
// data transfers and retire results; a negedge monitor compares them as the DUT emits them.
module tb_mc_cpu_core;
  localparam int DATA_W  = 16;
  localparam int REG_CNT = 8;
  localparam int PC_W    = 12;
  localparam int IMEM_SZ = 1 << PC_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic [DATA_W-1:0] DataOut;
  logic              retire;
  logic              halted;

  mc_cpu_core_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();

  mc_cpu_core #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .PC_W(PC_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .bus     (bus),
    .DataOut (DataOut),
    .retire  (retire),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                lat;
    logic [DATA_W-1:0] dout;
    bit                halt;
  } ret_t;

  typedef struct {
    logic [DATA_W-1:0] addr;
    bit                we;
    logic [DATA_W-1:0] wdata;
  } dtx_t;

  logic [15:0]       imem    [IMEM_SZ];
  logic [DATA_W-1:0] dmem    [256];
  logic [DATA_W-1:0] mdl_mem [256];
  logic [DATA_W-1:0] mdl_rf  [16];
  ret_t              ret_q[$];
  dtx_t              dtx_q[$];
  logic [PC_W-1:0]   fetch_q[$];

  int n_vec  = 0;
  int n_fail = 0;
  int n_ret  = 0;

  bit hold_acks = 1'b1;
  bit freeze_en = 1'b0;
  int imode = 0;
  int dmode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: event with empty expectation queue", name);
  endtask

  // ---------------- reference model (instruction level) ----------------
  function automatic logic [DATA_W-1:0] rf_get(input logic [3:0] idx);
    if (idx == 4'd0 || int'(idx) >= REG_CNT) return '0;
    return mdl_rf[idx];
  endfunction

  task automatic model_run();
    int                pc;
    int                nxt;
    int                lat;
    bit                halt;
    logic [15:0]       ins;
    logic [3:0]        op, rd, rs, rt;
    logic [DATA_W-1:0] a, b, d, imm, val, ea, dout;
    ret_t              r;
    dtx_t              t;
    for (int i = 0; i < 16; i++) mdl_rf[i] = '0;
    pc   = 0;
    dout = '0;
    halt = 1'b0;
    for (int step = 0; step < 4000 && !halt; step++) begin
      ins = imem[pc];
      fetch_q.push_back(PC_W'(pc));
      {op, rd, rs, rt} = ins;
      a   = rf_get(rs);
      b   = rf_get(rt);
      d   = rf_get(rd);
      imm = DATA_W'($signed(rt));
      nxt = (pc + 1) % IMEM_SZ;
      lat = 2;
      val = '0;
      case (op)
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
          case (op)
            4'd1:    val = a + b;
            4'd2:    val = a - b;
            4'd3:    val = a & b;
            4'd4:    val = a | b;
            default: val = a + imm;
          endcase
          dout = val;
          if (rd != 4'd0 && int'(rd) < REG_CNT) mdl_rf[rd] = val;
          lat = 3;
        end
        4'd6: begin
          ea = a + imm;
          t.addr = ea; t.we = 1'b0; t.wdata = '0;
          dtx_q.push_back(t);
          val  = mdl_mem[ea[7:0]];
          dout = val;
          if (rd != 4'd0 && int'(rd) < REG_CNT) mdl_rf[rd] = val;
          lat = 4;
        end
        4'd7: begin
          ea = a + imm;
          t.addr = ea; t.we = 1'b1; t.wdata = d;
          dtx_q.push_back(t);
          mdl_mem[ea[7:0]] = d;
          lat = 3;
        end
        4'd8: if (d == a) nxt = (pc + 1 + int'($signed(rt)) + IMEM_SZ) % IMEM_SZ;
        4'd9: nxt = int'(ins[11:0]) % IMEM_SZ;
        4'd10: begin
`ifdef MC_CPU_MUL_EN
          val  = DATA_W'(longint'(a) * longint'(b));
          dout = val;
          if (rd != 4'd0 && int'(rd) < REG_CNT) mdl_rf[rd] = val;
          lat = 3;
`endif
        end
        4'd15: halt = 1'b1;
        default: ;
      endcase
      r.lat = lat; r.dout = dout; r.halt = halt;
      ret_q.push_back(r);
      pc = nxt;
    end
  endtask

  // ---------------- memory responder / enable control ----------------
  int freeze_cnt = 0;
  int dwait      = 0;

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      enable       = 1'b1;
      freeze_cnt   = 0;
      dwait        = 0;
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
    end else if (freeze_cnt > 0) begin
      enable       = 1'b0;
      bus.imem_ack = 1'($urandom_range(0, 1));
      bus.dmem_ack = 1'($urandom_range(0, 1));
      freeze_cnt--;
    end else if (freeze_en && bus.dmem_req && $urandom_range(0, 1) == 0) begin
      enable       = 1'b0;
      bus.imem_ack = 1'($urandom_range(0, 1));
      bus.dmem_ack = 1'b1;
      freeze_cnt   = 4;
    end else begin
      enable = 1'b1;
      if (hold_acks) begin
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
      end else begin
        bus.imem_ack = (imode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (dmode == 0) begin
          bus.dmem_ack = 1'b1;
        end else if (dmode == 1) begin
          bus.dmem_ack = 1'($urandom_range(0, 1));
        end else begin
          dwait        = bus.dmem_req ? dwait + 1 : 0;
          bus.dmem_ack = (dwait >= 3);
        end
      end
    end
    bus.imem_rdata = imem[bus.imem_addr];
    bus.dmem_rdata = dmem[bus.dmem_addr[7:0]];
  end

  // ---------------- monitor / scoreboard ----------------
  int                lat     = 0;
  bit                en_last = 1'b0;
  bit                pend_i  = 1'b0;
  bit                pend_d  = 1'b0;
  logic [PC_W-1:0]   snap_ia;
  logic [DATA_W-1:0] snap_da, snap_dw;
  bit                snap_we;

  always @(negedge clk) begin
    ret_t              r;
    dtx_t              t;
    logic [PC_W-1:0]   pc;
    if (!reset) begin
      lat     = 0;
      en_last = 1'b0;
      pend_i  = 1'b0;
      pend_d  = 1'b0;
    end else begin
      if (retire && en_last) begin
        if (ret_q.size() == 0) begin
          fail_event("unexpected_retire");
        end else begin
          r = ret_q.pop_front();
          n_ret++;
          $display("retire %0d: DataOut=%h cycles=%0d halted=%0b", n_ret, DataOut, lat + 1, halted);
          check("retire_latency", 32'(lat), 32'(r.lat));
          check("DataOut", 32'(DataOut), 32'(r.dout));
          check("halted", 32'(halted), 32'(r.halt));
        end
      end
      if (halted) check("imem_req_in_halt", 32'(bus.imem_req), 32'd0);
      if (pend_i) begin
        check("imem_req_held", 32'(bus.imem_req), 32'd1);
        check("imem_addr_held", 32'(bus.imem_addr), 32'(snap_ia));
      end
      if (pend_d) begin
        check("dmem_req_held", 32'(bus.dmem_req), 32'd1);
        check("dmem_addr_held", 32'(bus.dmem_addr), 32'(snap_da));
        check("dmem_we_held", 32'(bus.dmem_we), 32'(snap_we));
        check("dmem_wdata_held", 32'(bus.dmem_wdata), 32'(snap_dw));
      end
      if (enable) begin
        if (bus.imem_req && bus.imem_ack) begin
          if (fetch_q.size() == 0) begin
            fail_event("unexpected_fetch");
          end else begin
            pc = fetch_q.pop_front();
            check("fetch_addr", 32'(bus.imem_addr), 32'(pc));
          end
          lat = 0;
        end else if (!(bus.dmem_req && !bus.dmem_ack)) begin
          lat++;
        end
        if (bus.dmem_req && bus.dmem_ack) begin
          if (dtx_q.size() == 0) begin
            fail_event("unexpected_dmem");
          end else begin
            t = dtx_q.pop_front();
            check("dmem_addr", 32'(bus.dmem_addr), 32'(t.addr));
            check("dmem_we", 32'(bus.dmem_we), 32'(t.we));
            if (t.we) check("dmem_wdata", 32'(bus.dmem_wdata), 32'(t.wdata));
          end
          if (bus.dmem_we) dmem[bus.dmem_addr[7:0]] = bus.dmem_wdata;
        end
      end
      pend_i  = bus.imem_req && !(enable && bus.imem_ack);
      pend_d  = bus.dmem_req && !(enable && bus.dmem_ack);
      snap_ia = bus.imem_addr;
      snap_da = bus.dmem_addr;
      snap_dw = bus.dmem_wdata;
      snap_we = bus.dmem_we;
      en_last = enable;
    end
  end

  // ---------------- program runner ----------------
  task automatic run_prog(input int im, input int dm, input bit frz);
    int cyc;
    for (int i = 0; i < 256; i++) begin
      dmem[i]    = DATA_W'($urandom());
      mdl_mem[i] = dmem[i];
    end
    hold_acks = 1'b1;
    freeze_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("fetch_req_pending", 32'(bus.imem_req), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
    check("rst_dmem_we", 32'(bus.dmem_we), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_DataOut", 32'(DataOut), 32'd0);
    check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    fetch_q.delete();
    dtx_q.delete();
    ret_q.delete();
    model_run();
    imode     = im;
    dmode     = dm;
    hold_acks = 1'b0;
    freeze_en = frz;
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    while (!halted && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    if (!halted) begin
      n_vec++;
      n_fail++;
      $display("FAIL halt_timeout: halted=%0b after %0d cycles, required 1", halted, cyc);
    end
    repeat (6) @(negedge clk);
    check("left_retires", 32'(ret_q.size()), 32'd0);
    check("left_fetches", 32'(fetch_q.size()), 32'd0);
    check("left_dmem", 32'(dtx_q.size()), 32'd0);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < IMEM_SZ; i++) imem[i] = 16'h0000;
  endtask

  task automatic load_p1();
    clear_imem();
    imem[0]  = 16'h5105;  // ADDI r1,r0,5
    imem[1]  = 16'h520D;  // ADDI r2,r0,-3
    imem[2]  = 16'h1312;  // ADD  r3,r1,r2
    imem[3]  = 16'h7304;  // ST   r3,[r0+4]
    imem[4]  = 16'h6404;  // LD   r4,[r0+4]
    imem[5]  = 16'h900A;  // JMP  10
    imem[9]  = 16'h900B;  // JMP  11
    imem[10] = 16'h811E;  // BEQ  r1,r1,-2 -> 9
    imem[11] = 16'h8123;  // BEQ  r1,r2,+3 (unequal) -> 12
    imem[12] = 16'h5901;  // ADDI r9,r0,1 (beyond REG_CNT, dropped)
    imem[13] = 16'h1599;  // ADD  r5,r9,r9 -> 0
    imem[14] = 16'h5009;  // ADDI r0,r0,9 (dropped)
    imem[15] = 16'h1600;  // ADD  r6,r0,r0 -> 0
    imem[16] = 16'h5201;  // ADDI r2,r0,1
    for (int i = 17; i < 25; i++) imem[i] = 16'h1222;  // r2 doubles to 0x0100
    imem[25] = 16'h5321;  // ADDI r3,r2,1 -> 0x0101
    imem[26] = 16'hA123;  // MUL  r1,r2,r3
    imem[27] = 16'hF000;  // HALT
  endtask

  task automatic load_p2();
    clear_imem();
    imem[0]     = 16'h8501;  // BEQ r5,r0,+1
    imem[1]     = 16'hF000;  // HALT
    imem[2]     = 16'h5501;  // ADDI r5,r0,1
    imem[3]     = 16'h9FFF;  // JMP 0xFFF
    imem[12'hFFF] = 16'h0000;  // NOP, PC wraps to 0
  endtask

  task automatic load_random();
    int         n;
    int         room;
    logic [3:0] op, rd, rs, rt;
    clear_imem();
    n = $urandom_range(20, 40);
    for (int pc = 0; pc < n - 1; pc++) begin
      op = 4'($urandom_range(0, 15));
      rd = 4'($urandom_range(0, 9));
      rs = 4'($urandom_range(0, 9));
      rt = 4'($urandom_range(0, 15));
      room = n - 2 - pc;
      if (op == 4'd15) op = 4'd5;
      if (op == 4'd8) begin
        if ($urandom_range(0, 1) == 1) rd = rs;
        rt = 4'($urandom_range(0, (room < 7) ? room : 7));
      end
      if (op == 4'd9) begin
        imem[pc] = {4'd9, 12'(pc + 1 + $urandom_range(0, (room < 3) ? room : 3))};
      end else begin
        imem[pc] = {op, rd, rs, rt};
      end
    end
    imem[n-1] = 16'hF000;
  endtask

  initial begin
    bus.imem_ack   = 1'b0;
    bus.dmem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.dmem_rdata = '0;
    clear_imem();
    repeat (2) @(negedge clk);

    load_p1();
    run_prog(0, 0, 1'b0);  // zero-wait
    run_prog(0, 2, 1'b0);  // two wait states on every data access
    run_prog(0, 0, 1'b1);  // enable freezes during MEM
    load_p2();
    run_prog(0, 0, 1'b0);  // PC wrap at 0xFFF
    for (int k = 0; k < 12; k++) begin
      int dm;
      load_random();
      dm = $urandom_range(0, 2);
      run_prog($urandom_range(0, 1), dm, (dm != 2) && ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
